// File: rtl/sm2_final_reduce.sv
// Final reduction of a 256-bit SM2 product into [0, p) using a limb-serial conditional subtract.
// Build option: define MODRED_CT_EN for constant-time operation (no fast path).
module sm2_final_reduce #(
    parameter  int LIMB_W = 64,
    localparam int NLIMB  = 256 / LIMB_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_data,
    output logic         out_sub,
    output logic         busy
);

    localparam int IW = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [255:0] P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t         state_q, state_d;
    logic [255:0]   a_q, a_d;
    logic [255:0]   d_q, d_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           borrow_q, borrow_d;
    logic [255:0]   out_data_q, out_data_d;
    logic           out_sub_q, out_sub_d;

    logic [LIMB_W-1:0] a_limb, p_limb, diff;
    logic              borrow_n;

    assign a_limb = a_q[idx_q*LIMB_W +: LIMB_W];
    assign p_limb = P[idx_q*LIMB_W +: LIMB_W];
    assign {borrow_n, diff} = {1'b0, a_limb} - {1'b0, p_limb} - {{LIMB_W{1'b0}}, borrow_q};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            a_q        <= '0;
            d_q        <= '0;
            idx_q      <= '0;
            borrow_q   <= 1'b0;
            out_data_q <= '0;
            out_sub_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            d_q        <= d_d;
            idx_q      <= idx_d;
            borrow_q   <= borrow_d;
            out_data_q <= out_data_d;
            out_sub_q  <= out_sub_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        d_d        = d_q;
        idx_d      = idx_q;
        borrow_d   = borrow_q;
        out_data_d = out_data_q;
        out_sub_d  = out_sub_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = in_data;
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = SUB;
`ifndef MODRED_CT_EN
                    // A top word below FFFFFFFE guarantees the value is already < p.
                    if (in_data[255:224] < 32'hFFFF_FFFE) begin
                        state_d    = DONE;
                        out_data_d = in_data;
                        out_sub_d  = 1'b0;
                    end
`endif
                end
            end
            SUB: begin
                d_d[idx_q*LIMB_W +: LIMB_W] = diff;
                borrow_d = borrow_n;
                idx_d    = idx_q + IW'(1);
                if (idx_q == IW'(NLIMB - 1)) begin
                    // d_d already carries the final limb, so it is the full a-p.
                    out_data_d = borrow_n ? a_q : d_d;
                    out_sub_d  = ~borrow_n;
                    idx_d      = '0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_sub   = out_sub_q;

endmodule

// File: doc/sm2_final_reduce.md
Name: sm2_final_reduce

Overview:
- Downstream stage of the 256-bit SM2 Montgomery-free modular multiplier.
- Takes its 256-bit pseudo-reduced product (any value 0..2^256-1) and returns the canonical residue in [0, p).
- p = 2^256 - 2^224 - 2^96 + 2^64 - 1 = FFFFFFFE FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF 00000000 FFFFFFFF FFFFFFFF (hex, MS word first).
- Uses an iterative limb-serial conditional subtract with valid/ready handshakes on both sides, so the wide single-cycle 256-bit compare stays off the multiplier's critical path.

Parameters:
- LIMB_W, 64, subtractor limb width in bits. Legal values: 32, 64, 128.
- NLIMB, 256/LIMB_W, number of limbs (derived; not overridden).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept; equals (state==IDLE)
- in_data  in  256  pseudo-reduced value, unsigned
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  256  canonical residue, in_data mod p
- out_sub  out  1  1 = p was subtracted
- busy  out  1  state != IDLE

Behaviour:
- Reset is synchronous on clk, active-low rstn.
  - Reset values: state=IDLE, out_valid=0, out_data=0, out_sub=0, busy=0, limb index=0, borrow=0.
  - in_ready is 1 once state=IDLE; in_valid is ignored while rstn=0.
- Correctness bound: one subtraction always suffices, since 2^256-1-p = 2^224+2^96-2^64 < p.
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - On in_valid&in_ready, latch in_data into a_reg, clear borrow and idx, go to SUB.
  - Fast path applies only when ifndef MODRED_CT_EN; see Optional Feature.
- SUB, one limb per cycle, LS limb first:
  - {borrow_n, diff_limb} = a_limb[idx] - p_limb[idx] - borrow.
  - Store diff_limb into d_reg[idx]; borrow <= borrow_n; idx <= idx+1.
  - The p limbs are constants sliced from the 256-bit literal by idx; no RAM.
  - After limb NLIMB-1:
    - If final borrow=0 (a>=p): out_data <= d_reg with the last limb merged, out_sub <= 1.
    - Else: out_data <= a_reg, out_sub <= 0.
    - Then go to DONE.
- DONE:
  - out_valid=1; out_data and out_sub are held stable while out_ready=0.
  - On out_ready, clear out_valid and go to IDLE.
  - A new input cannot be accepted in the same cycle as out_ready (in_ready=0 in DONE).
- Latency (T = accept cycle): out_valid first high in cycle T+NLIMB+1 (T+5 at default).
- Throughput: one result per NLIMB+2 cycles without backpressure.
- Reset mid-operation: any state returns to IDLE next cycle, out_valid drops, and partial results are discarded.
- out_data changes only on the DONE entry edge.
- in_data need not be held after acceptance.

Optional Feature:
- Macro: MODRED_CT_EN.
- Defined (constant-time): every operand takes the full SUB path, latency always NLIMB+1, no data-dependent timing. This is the required build for key-dependent data.
- Undefined (fast path):
  - In IDLE on accept, if in_data[255:224] < 32'hFFFFFFFE, the value is < p.
  - It goes directly to DONE with out_data=in_data, out_sub=0, so out_valid is high in cycle T+1.
  - All other operands take the full path.

Test Plan:
- in_data = p -> out_data = 0, out_sub=1, out_valid at T+5 (LIMB_W=64).
- in_data = p-1 -> out_data = p-1, out_sub=0, full path (top word FFFFFFFE), out_valid at T+5.
- in_data = 2^256-1 -> out_data = 00000001 00000000 00000000 00000000 00000000 FFFFFFFF 00000000 00000000, out_sub=1.
- in_data = 5:
  - Without MODRED_CT_EN: out_data=5, out_valid at T+1.
  - With MODRED_CT_EN: out_data=5, out_valid at T+5.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid, out_data and out_sub stable, in_ready=0. Then a 1-cycle out_ready pulse -> out_valid=0 and in_ready=1 next cycle.
- Reset mid-operation: assert rstn=0 for 1 cycle during SUB (idx=2) -> next cycle state IDLE, out_valid=0, busy=0. A following in_data=p+7 then yields out_data=7, out_sub=1.
- Repeat all cases with LIMB_W=32 (latency T+9) and LIMB_W=128 (latency T+3).
